// File: rtl/mod7_seq_monitor.sv
// Sequence checker for a synchronous mod-7 counter: verifies each sample is the
// previous one plus 1 (mod 7), counts completed periods and faults, and relocks on 0.
module mod7_seq_monitor #(
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             Cp,
  input  logic             R,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             clr,
  output logic             wrap,
  output logic             restart,
  output logic             err,
  output logic             locked,
  output logic [CYC_W-1:0] cycles,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    START  = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] v;
  logic [2:0] prev;
  logic       wrap_p0, restart_p0, err_p0;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  assign v      = {y3, y2, y1};
  assign locked = (state == TRACK);

  // Stage p0: classify the current sample against the previous one.
  always_comb begin
    state_nxt  = state;
    wrap_p0    = 1'b0;
    restart_p0 = 1'b0;
    err_p0     = 1'b0;
    unique case (state)
      START: state_nxt = TRACK;
      TRACK: begin
        if (v == 3'd7) begin
          err_p0 = 1'b1;
        end else if (prev == 3'd6 && v == 3'd0) begin
          wrap_p0 = 1'b1;
        end else if (prev <= 3'd5 && v == prev + 3'd1) begin
          // in sequence, nothing to report
        end else if (v == 3'd0) begin
          // counter was reset mid-period; prev may even be 7 after START
          restart_p0 = 1'b1;
        end else begin
          err_p0 = 1'b1;
        end
        if (err_p0) state_nxt = RESYNC;
      end
      RESYNC: if (v == 3'd0) state_nxt = TRACK;
      default: state_nxt = START;
    endcase
  end

  // Stage p0 -> registered outputs and counters.
  always_ff @(posedge Cp) begin
    if (R) begin
      state   <= START;
      prev    <= 3'd0;
      wrap    <= 1'b0;
      restart <= 1'b0;
      err     <= 1'b0;
      cycles  <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      prev    <= v;
      wrap    <= wrap_p0;
      restart <= restart_p0;
      err     <= err_p0;
      if (clr) begin
        cycles  <= '0;
        err_cnt <= '0;
      end else begin
        if (wrap_p0) cycles  <= cycles + 1'b1;
        if (err_p0)  err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mod7_seq_monitor.sv
// Randomised and directed bench for mod7_seq_monitor against a rule-level model
// (sequence expectation computed as (prev+1)%7 with an "in sequence" flag).
module tb_mod7_seq_monitor;

  logic       Cp = 1'b0;
  logic       R = 1'b1;
  logic       y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;
  logic       clr = 1'b0;
  logic       wrap, restart, err, locked;
  logic [7:0] cycles;
  logic [3:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         m_prev = 0;
  bit         m_fresh = 1'b0;
  bit         m_in_seq = 1'b0;
  logic       m_wrap = 0, m_restart = 0, m_err = 0;
  logic [7:0] m_cyc = 0;
  logic [3:0] m_ec = 0;

  mod7_seq_monitor #(.CYC_W(8), .ERR_W(4)) dut (
    .Cp(Cp), .R(R), .y1(y1), .y2(y2), .y3(y3), .clr(clr),
    .wrap(wrap), .restart(restart), .err(err), .locked(locked),
    .cycles(cycles), .err_cnt(err_cnt)
  );

  always #5 Cp = ~Cp;

  function automatic logic [15:0] obs();
    return {wrap, restart, err, locked, cycles, err_cnt};
  endfunction

  function automatic logic [15:0] expv();
    return {m_wrap, m_restart, m_err, m_in_seq, m_cyc, m_ec};
  endfunction

  task automatic step(input int v, input logic r, input logic c);
    {y3, y2, y1} = 3'(v);
    R   = r;
    clr = c;
    @(posedge Cp);
    m_wrap = 0; m_restart = 0; m_err = 0;
    if (r) begin
      m_prev = 0; m_fresh = 1; m_in_seq = 0; m_cyc = 0; m_ec = 0;
    end else begin
      if (m_fresh) begin
        m_fresh = 0;
        m_in_seq = 1;
      end else if (m_in_seq) begin
        if (v == 7)                          m_err = 1;
        else if (m_prev == 6 && v == 0)      m_wrap = 1;
        else if (m_prev < 6 && v == m_prev + 1) ;
        else if (v == 0)                     m_restart = 1;
        else                                 m_err = 1;
        if (m_err) begin
          m_in_seq = 0;
          if (m_ec != 4'd15) m_ec = m_ec + 4'd1;
        end
        if (m_wrap) m_cyc = m_cyc + 8'd1;
      end else if (v == 0) begin
        m_in_seq = 1;
      end
      if (c) begin
        m_cyc = 0; m_ec = 0;
      end
      m_prev = v;
    end
    #1;
  endtask

  task automatic test_reset();
    step(5, 1'b1, 1'b0);
    n_vec++;
    if (obs() !== 16'h0000) begin
      n_err++; $display("FAIL reset obs=%h exp=%h", obs(), 16'h0000);
    end
  endtask

  task automatic test_nominal();
    int wraps = 0, bad = 0;
    step(0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(i % 7, 1'b0, 1'b0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL nominal[%0d] obs=%h exp=%h", i, obs(), expv());
      end
      if (wrap) wraps++;
      if (err || restart || (locked !== 1'b1)) bad++;
    end
    n_vec++;
    if (wraps != 2 || cycles !== 8'd2 || err_cnt !== 4'd0 || bad != 0) begin
      n_err++;
      $display("FAIL nominal_totals wraps=%0d cycles=%0d err_cnt=%0d bad=%0d exp 2/2/0/0",
               wraps, cycles, err_cnt, bad);
    end
  endtask

  task automatic test_illegal();
    int seq[5] = '{3, 4, 7, 0, 1};
    step(0, 1'b1, 1'b0);
    foreach (seq[i]) begin
      step(seq[i], 1'b0, 1'b0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL illegal[%0d] obs=%h exp=%h", i, obs(), expv());
      end
      if (i == 2) begin
        n_vec++;
        if ({err, locked, err_cnt} !== {1'b1, 1'b0, 4'd1}) begin
          n_err++; $display("FAIL illegal_on7 err/locked/cnt=%b/%b/%0d exp 1/0/1", err, locked, err_cnt);
        end
      end
      if (i == 3) begin
        n_vec++;
        if ({locked, wrap, restart} !== 3'b100) begin
          n_err++; $display("FAIL illegal_relock lk/wr/rs=%b exp 100", {locked, wrap, restart});
        end
      end
      if (i == 4) begin
        n_vec++;
        if ({wrap, restart, err, locked} !== 4'b0001) begin
          n_err++; $display("FAIL illegal_after obs=%b exp 0001", {wrap, restart, err, locked});
        end
      end
    end
  endtask

  task automatic test_skip_hold();
    int seq[6] = '{2, 4, 5, 6, 0, 1};
    logic [3:0] want[6] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    step(0, 1'b1, 1'b0);
    foreach (seq[i]) begin
      step(seq[i], 1'b0, 1'b0);
      n_vec++;
      if ({wrap, restart, err, locked} !== want[i] || obs() !== expv()) begin
        n_err++; $display("FAIL skip[%0d] obs=%h exp=%h flags_exp=%b", i, obs(), expv(), want[i]);
      end
    end
    step(0, 1'b1, 1'b0);
    step(3, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);
    n_vec++;
    if ({err, locked, err_cnt} !== {1'b1, 1'b0, 4'd1}) begin
      n_err++; $display("FAIL hold3 err/locked/cnt=%b/%b/%0d exp 1/0/1", err, locked, err_cnt);
    end
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1'b0, 1'b0);
      n_vec++;
      if ({wrap, restart, err, locked} !== 4'b0101 || obs() !== expv()) begin
        n_err++; $display("FAIL hold0[%0d] obs=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_restart();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    step(0, 1'b1, 1'b0);
    foreach (seq[i]) begin
      step(seq[i], 1'b0, 1'b0);
      n_vec++;
      if (obs() !== expv() || restart !== (i == 4) || err !== 1'b0 || cycles !== 8'd0
          || locked !== 1'b1) begin
        n_err++; $display("FAIL restart[%0d] obs=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    int errs = 0;
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(7, 1'b0, 1'b0);
      if (err) errs++;
      step(0, 1'b0, 1'b0);
    end
    n_vec++;
    if (errs != 20 || err_cnt !== 4'd15 || obs() !== expv()) begin
      n_err++; $display("FAIL saturation errs=%0d err_cnt=%0d exp 20/15", errs, err_cnt);
    end
  endtask

  task automatic test_rollover();
    int wraps = 0;
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int p = 0; p < 256; p++) begin
      for (int k = 1; k <= 7; k++) begin
        step(k % 7, 1'b0, 1'b0);
        if (wrap) wraps++;
      end
      if (p == 254) begin
        n_vec++;
        if (cycles !== 8'd255) begin
          n_err++; $display("FAIL rollover_255 cycles=%0d exp 255", cycles);
        end
      end
    end
    n_vec++;
    if (wraps != 256 || cycles !== 8'd0 || obs() !== expv()) begin
      n_err++; $display("FAIL rollover wraps=%0d cycles=%0d exp 256/0", wraps, cycles);
    end
  endtask

  task automatic test_clr_reset();
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) step(k, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    n_vec++;
    if ({wrap, locked, cycles, err_cnt} !== {1'b1, 1'b1, 8'd0, 4'd0} || obs() !== expv()) begin
      n_err++; $display("FAIL clr_on_wrap obs=%h exp=%h", obs(), expv());
    end
    step(1, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    n_vec++;
    if (obs() !== 16'h0000) begin
      n_err++; $display("FAIL reset_mid obs=%h exp=%h", obs(), 16'h0000);
    end
    for (int k = 1; k <= 6; k++) step(k, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1);
    n_vec++;
    if (obs() !== 16'h0000) begin
      n_err++; $display("FAIL reset_clr obs=%h exp=%h", obs(), 16'h0000);
    end
    step(1, 1'b0, 1'b0);
    n_vec++;
    if ({wrap, restart, err, locked} !== 4'b0001) begin
      n_err++; $display("FAIL reset_relock obs=%b exp 0001", {wrap, restart, err, locked});
    end
  endtask

  task automatic test_random();
    int v, r;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      v = (m_prev + 1) % 7;
      else if (r < 93) v = $urandom_range(0, 7);
      else             v = 0;
      step(v, ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
      n_vec++;
      if (obs() !== expv()) begin
        n_err++; $display("FAIL random[%0d] v=%0d obs=%h exp=%h", i, v, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_illegal();
    test_skip_hold();
    test_restart();
    test_saturation();
    test_rollover();
    test_clr_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
